// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: DEPTH chained stages of {valid, data, ctrl}
// with stall, flush and a registered count of valid stages.
module pipe_stage_reg #(
    parameter int unsigned              DATA_W      = 32,
    parameter int unsigned              CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]        CTRL_BUBBLE = '0,
    parameter int unsigned              DEPTH       = 1,
    localparam int unsigned             OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_depth_chk
        $error("pipe_stage_reg: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        occ_d   = '0;
        if (flush) begin
            // Data is left in place; only valid and ctrl are squashed.
            valid_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctrl_d[i] = CTRL_BUBBLE;
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            ctrl_d[0]  = in_valid ? in_ctrl : CTRL_BUBBLE;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= CTRL_BUBBLE;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
